// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Build option BCD2BIN_CHECK_EN enables the non-decimal digit check.
package bcd_to_bin_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle of the BCD-to-binary converter.
// master drives requests, slave is the converter.
interface bcd_to_bin_if #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
);
    import bcd_to_bin_pkg::*;

    logic                          start;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in;
    logic                          ready;
    logic                          done;
    logic [OUT_W-1:0]              bin_out;
    logic                          err;

    modport master (
        output start, bcd_in,
        input  ready, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, bin_out, err
    );

endinterface

// File: rtl/bcd_to_bin_mul10_add.sv
// Combinational acc*10 + digit built from two shifts and adds, no multiplier.
// Result is truncated to OUT_W bits; callers size OUT_W so legal inputs never wrap.
module mul10_add
    import bcd_to_bin_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic [OUT_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]   result
);

    logic [OUT_W-1:0] acc_x8;
    logic [OUT_W-1:0] acc_x2;
    logic [OUT_W-1:0] digit_ext;

    assign acc_x8    = acc << 3;
    assign acc_x2    = acc << 1;
    assign digit_ext = OUT_W'(digit);
    assign result    = acc_x8 + acc_x2 + digit_ext;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD2BIN_CHECK_EN to flag non-decimal digits via err (result forced to 0).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready=1, waiting for start; latches bcd_in on acceptance
//   ST_CONV | one digit folded into the accumulator per cycle
//   ST_DONE | done pulse; bin_out/err already hold the new result
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    bcd_to_bin_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [BCD_W-1:0]   bcd_q;
    logic [OUT_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OUT_W-1:0]   bin_q;
    logic               err_q;

    logic [DIGIT_W-1:0] digit;
    logic [OUT_W-1:0]   acc_next;
    logic               accept;
    logic               conv_step;
    logic               last_digit;
    logic [OUT_W-1:0]   fin_bin;
    logic               fin_err;

    assign accept     = (state_q == ST_IDLE) && bus.start;
    assign conv_step  = (state_q == ST_CONV);
    assign last_digit = (idx_q == '0);
    assign digit      = bcd_q[idx_q*DIGIT_W +: DIGIT_W];

    mul10_add #(
        .OUT_W (OUT_W)
    ) u_mul10_add (
        .acc    (acc_q),
        .digit  (digit),
        .result (acc_next)
    );

`ifdef BCD2BIN_CHECK_EN
    logic bad_q;
    logic bad_now;

    assign bad_now = bad_q | digit_invalid(digit);

    always_ff @(posedge clk) begin
        if (!reset_n || accept) begin
            bad_q <= 1'b0;
        end else if (conv_step) begin
            bad_q <= bad_now;
        end
    end

    assign fin_err = bad_now;
    assign fin_bin = bad_now ? '0 : acc_next;
`else
    assign fin_err = 1'b0;
    assign fin_bin = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start)  state_d = ST_CONV;
            ST_CONV: if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers load on the last CONV step so they are valid alongside done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcd_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= bus.bcd_in;
            acc_q <= '0;
            idx_q <= IDX_W'(NUM_DIGITS - 1);
        end else if (conv_step) begin
            acc_q <= acc_next;
            idx_q <= idx_q - 1'b1;
            if (last_digit) begin
                bin_q <= fin_bin;
                err_q <= fin_err;
            end
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule
